// File: rtl/axis_arbiter_mux_if.sv
// axis_arbiter_mux_if: stream bundle between N packet sources, the merging mux and one sink.
//   axis_i_*  : N input streams packed side by side (input i in slice i)
//   axis_o_*  : merged output stream, axis_o_tdest names the source input
//   slave     : the mux's view; master: the sources/sink view
interface axis_arbiter_mux_if #(
    parameter int AXIS_BYTES        = 1,
    parameter int AXIS_USER_BITS    = 1,
    parameter int NUM_SLAVE_STREAMS = 2
);
    localparam int AXIS_DEST_BITS = (NUM_SLAVE_STREAMS == 1) ? 1 : $clog2(NUM_SLAVE_STREAMS);
    logic [NUM_SLAVE_STREAMS-1:0]                  axis_i_tready;
    logic [NUM_SLAVE_STREAMS-1:0]                  axis_i_tvalid;
    logic [NUM_SLAVE_STREAMS-1:0]                  axis_i_tlast;
    logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0]     axis_i_tdata;
    logic [NUM_SLAVE_STREAMS*AXIS_USER_BITS-1:0]   axis_i_tuser;
    logic                                          axis_o_tready;
    logic                                          axis_o_tvalid;
    logic                                          axis_o_tlast;
    logic [AXIS_BYTES*8-1:0]                       axis_o_tdata;
    logic [AXIS_USER_BITS-1:0]                     axis_o_tuser;
    logic [AXIS_DEST_BITS-1:0]                     axis_o_tdest;

    modport slave (
        output axis_i_tready,
        input  axis_i_tvalid, axis_i_tlast, axis_i_tdata, axis_i_tuser,
        input  axis_o_tready,
        output axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tuser, axis_o_tdest
    );

    modport master (
        input  axis_i_tready,
        output axis_i_tvalid, axis_i_tlast, axis_i_tdata, axis_i_tuser,
        output axis_o_tready,
        input  axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tuser, axis_o_tdest
    );
endinterface

// File: rtl/axis_arbiter_mux.sv
// axis_arbiter_mux: packet-level round-robin merge of N AXI-Stream inputs onto one output.
//   clk     : clock, rising edge
//   aresetn : asynchronous active-low reset
//   axis    : stream bundle (slave modport); axis_o_tdest carries the source index
module axis_arbiter_mux #(
    parameter int AXIS_BYTES        = 1,
    parameter int AXIS_USER_BITS    = 1,
    parameter int NUM_SLAVE_STREAMS = 2
) (
    input  logic              clk,
    input  logic              aresetn,
    axis_arbiter_mux_if.slave axis
);
    localparam int N  = NUM_SLAVE_STREAMS;
    localparam int DW = AXIS_BYTES * 8;
    localparam int UW = AXIS_USER_BITS;
    localparam int DB = (N == 1) ? 1 : $clog2(N);

    typedef enum logic {ARB, PASS} state_t;

    state_t        state;
    logic [DB-1:0] grant, rr_last, pick;
    logic          any_valid, room, take;

    // Walk from the farthest candidate back to rr_last+1 so the nearest valid one wins.
    always_comb begin
        pick      = rr_last;
        any_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (axis.axis_i_tvalid[DB'((int'(rr_last) + k) % N)]) begin
                pick      = DB'((int'(rr_last) + k) % N);
                any_valid = 1'b1;
            end
        end
    end

    assign room               = !axis.axis_o_tvalid || axis.axis_o_tready;
    assign take               = (state == PASS) && room && axis.axis_i_tvalid[grant];
    assign axis.axis_i_tready = (state == PASS && room) ? N'(1) << grant : '0;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= ARB;
            grant              <= '0;
            rr_last            <= DB'(N - 1);
            axis.axis_o_tvalid <= 1'b0;
            axis.axis_o_tlast  <= 1'b0;
            axis.axis_o_tdata  <= '0;
            axis.axis_o_tuser  <= '0;
            axis.axis_o_tdest  <= '0;
        end else begin
            // A beat loading below overrides this clear on the same edge.
            if (axis.axis_o_tready)
                axis.axis_o_tvalid <= 1'b0;
            if (state == ARB) begin
                if (any_valid) begin
                    grant <= pick;
                    state <= PASS;
                end
            end else if (take) begin
                axis.axis_o_tvalid <= 1'b1;
                axis.axis_o_tlast  <= axis.axis_i_tlast[grant];
                axis.axis_o_tdata  <= DW'(axis.axis_i_tdata >> (32'(grant) * DW));
                axis.axis_o_tuser  <= UW'(axis.axis_i_tuser >> (32'(grant) * UW));
                axis.axis_o_tdest  <= grant;
                if (axis.axis_i_tlast[grant]) begin
                    rr_last <= grant;
                    state   <= ARB;
                end
            end
        end
    end
endmodule
